// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral: oversamples SCK/SS/MOSI in the clk domain, captures four
// MSB-first receive slots and shifts four preloaded response words out on MISO.
module spi_peripheral #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 SCK,
    input  logic                 SS,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [DATA_BITS-1:0] tx_word0,
    input  logic [DATA_BITS-1:0] tx_word1,
    input  logic [DATA_BITS-1:0] tx_word2,
    input  logic [DATA_BITS-1:0] tx_word3,
    output logic [DATA_BITS-1:0] rx_word0,
    output logic [DATA_BITS-1:0] rx_word1,
    output logic [DATA_BITS-1:0] rx_word2,
    output logic [DATA_BITS-1:0] rx_word3,
    output logic                 rx_valid,
    output logic [1:0]           rx_index,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned RW = DATA_BITS - 1;

    typedef enum logic [1:0] {ARM, IDLE, ACTIVE} state_t;

    state_t state, state_nxt;

    logic sck_s1, sck_s2, sck_s3;
    logic ss_s1, ss_s2, ss_s3;
    logic mosi_s1, mosi_s2;
    logic sck_rise, sck_fall, ss_fall, ss_rise;

    logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [1:0]           slot, slot_nxt;
    logic [RW-1:0]        shift_rx, shift_rx_nxt;
    logic [DATA_BITS-1:0] shift_tx, shift_tx_nxt;
    logic [DATA_BITS-1:0] rx_mem [4];
    logic [DATA_BITS-1:0] rx_mem_nxt [4];
    logic [DATA_BITS-1:0] tx_next;
    logic                 miso_nxt, rx_valid_nxt, frame_done_nxt, frame_err_nxt, busy_nxt;
    logic [1:0]           rx_index_nxt;

    // SS synchronizer resets low so a reset released mid-frame cannot fake an ss_fall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {sck_s1, sck_s2, sck_s3} <= '0;
            {ss_s1, ss_s2, ss_s3}    <= '0;
            {mosi_s1, mosi_s2}       <= '0;
        end else begin
            sck_s1  <= SCK;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            ss_s1   <= SS;
            ss_s2   <= ss_s1;
            ss_s3   <= ss_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_s3;
    assign sck_fall = ~sck_s2 & sck_s3;
    assign ss_fall  = ~ss_s2 & ss_s3;
    assign ss_rise  = ss_s2 & ~ss_s3;

    always_comb begin
        tx_next = tx_word0;
        case (2'(slot + 2'd1))
            2'd0: tx_next = tx_word0;
            2'd1: tx_next = tx_word1;
            2'd2: tx_next = tx_word2;
            default: tx_next = tx_word3;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ARM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARM:    if (ss_s2)   state_nxt = IDLE;
            IDLE:   if (ss_fall) state_nxt = ACTIVE;
            ACTIVE: if (ss_rise) state_nxt = IDLE;
            default: state_nxt = ARM;
        endcase
    end

    // Next values for the datapath and the registered outputs
    always_comb begin
        bit_cnt_nxt    = bit_cnt;
        slot_nxt       = slot;
        shift_rx_nxt   = shift_rx;
        shift_tx_nxt   = shift_tx;
        rx_mem_nxt     = rx_mem;
        miso_nxt       = MISO;
        rx_valid_nxt   = 1'b0;
        rx_index_nxt   = rx_index;
        frame_done_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        busy_nxt       = (state_nxt == ACTIVE);
        case (state)
            IDLE: begin
                miso_nxt = 1'b0;
                if (ss_fall) begin
                    bit_cnt_nxt  = '0;
                    slot_nxt     = '0;
                    shift_tx_nxt = tx_word0;
                    miso_nxt     = tx_word0[DATA_BITS-1];
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    frame_done_nxt = 1'b1;
                    frame_err_nxt  = (bit_cnt != '0);
                    miso_nxt       = 1'b0;
                end else if (sck_rise) begin
                    shift_rx_nxt = RW'({shift_rx, mosi_s2});
                    bit_cnt_nxt  = CW'(bit_cnt + CW'(1));
                    if (bit_cnt == CW'(DATA_BITS - 1)) begin
                        rx_mem_nxt[slot] = {shift_rx, mosi_s2};
                        rx_valid_nxt     = 1'b1;
                        rx_index_nxt     = slot;
                        bit_cnt_nxt      = '0;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt != '0) begin
                        shift_tx_nxt = {shift_tx[DATA_BITS-2:0], 1'b0};
                        miso_nxt     = shift_tx[DATA_BITS-2];
                    end else begin
                        slot_nxt     = 2'(slot + 2'd1);
                        shift_tx_nxt = tx_next;
                        miso_nxt     = tx_next[DATA_BITS-1];
                    end
                end
            end
            default: miso_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= '0;
            slot       <= '0;
            shift_rx   <= '0;
            shift_tx   <= '0;
            for (int i = 0; i < 4; i++) rx_mem[i] <= '0;
            MISO       <= 1'b0;
            rx_valid   <= 1'b0;
            rx_index   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            bit_cnt    <= bit_cnt_nxt;
            slot       <= slot_nxt;
            shift_rx   <= shift_rx_nxt;
            shift_tx   <= shift_tx_nxt;
            rx_mem     <= rx_mem_nxt;
            MISO       <= miso_nxt;
            rx_valid   <= rx_valid_nxt;
            rx_index   <= rx_index_nxt;
            frame_done <= frame_done_nxt;
            frame_err  <= frame_err_nxt;
            busy       <= busy_nxt;
        end
    end

    assign rx_word0 = rx_mem[0];
    assign rx_word1 = rx_mem[1];
    assign rx_word2 = rx_mem[2];
    assign rx_word3 = rx_mem[3];

endmodule
